// File: rtl/hwt_pkg.sv
// Shared definitions for the NonHWT sweep checker: vector width, FSM state
// encoding and the golden model of the checked logic cone.
package hwt_pkg;

    localparam int unsigned VEC_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } hwt_state_e;

    // Golden cone Y = D & ((A & B) | C), with vec = {A, B, C, D}.
    function automatic logic golden_y(input logic [VEC_W-1:0] vec);
        return vec[0] & ((vec[3] & vec[2]) | vec[1]);
    endfunction

endpackage

// File: rtl/hwt_err_accum.sv
// Mismatch accumulator: saturating error counter plus a first-failure
// capture register that is written once per run and then held.
module hwt_err_accum
    import hwt_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             mismatch_i,
    input  logic [VEC_W-1:0] vec_i,
    output logic [CNT_W-1:0] err_count_o,
    output logic [VEC_W-1:0] first_err_vec_o,
    output logic             first_err_valid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [VEC_W-1:0] fvec_q,  fvec_d;
    logic             valid_q, valid_d;

    // Next-state: clear on a new run, otherwise count and capture on a sampled mismatch.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        cnt_d   = cnt_q;
        fvec_d  = fvec_q;
        valid_d = valid_q;
        if (clr_i) begin
            cnt_d   = '0;
            fvec_d  = '0;
            valid_d = 1'b0;
        end else if (en_i && mismatch_i) begin
            // Saturate at all-ones; the counter never wraps back to zero.
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            // Only the first failing vector of a run is kept.
            if (!valid_q) begin
                fvec_d  = vec_i;
                valid_d = 1'b1;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fvec_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            cnt_q   <= cnt_d;
            fvec_q  <= fvec_d;
            valid_q <= valid_d;
        end
    end

    assign err_count_o       = cnt_q;
    assign first_err_vec_o   = fvec_q;
    assign first_err_valid_o = valid_q;

endmodule

// File: rtl/hwt_sweep_checker.sv
// Sweep driver and checker for the NonHWT cone: drives all 16 input vectors,
// lets each settle, samples dut_y and scores it against the golden function.
module hwt_sweep_checker
    import hwt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam logic [VEC_W-1:0] VEC_MAX     = '1;
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
    // The SAMPLE cycle that advances the vector already shows it on the pins,
    // so later vectors spend SETTLE_CYCLES cycles in DRIVE by reloading one less.
    localparam logic [3:0]       SETTLE_RELOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       LAST_PASS     = 8'(PASSES - 1);

    hwt_state_e       state_q,  state_d;
    logic [VEC_W-1:0] vec_q,    vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       pass_q,   pass_d;
    logic             acc_clr;
    logic             acc_en;
    logic             mismatch;

    assign mismatch = dut_y ^ golden_y(vec_q);

    // Next-state and control: start handling, settle countdown, vector/pass stepping.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        pass_d   = pass_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    vec_d    = '0;
                    pass_d   = '0;
                    settle_d = SETTLE_INIT;
                    acc_clr  = 1'b1;
                end
            end
            DRIVE: begin
                if (settle_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                acc_en = 1'b1;
                if (vec_q == VEC_MAX && pass_q == LAST_PASS) begin
                    state_d = DONE;
                end else begin
                    // vec wraps 15 -> 0 naturally at the end of a pass.
                    vec_d    = vec_q + 4'd1;
                    settle_d = SETTLE_RELOAD;
                    if (vec_q == VEC_MAX) begin
                        pass_d = pass_q + 8'd1;
                    end
                    state_d = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, vector and counter registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            pass_q   <= pass_d;
        end
    end

    hwt_err_accum #(
        .CNT_W (CNT_W)
    ) u_err_accum (
        .clk               (clk),
        .rst_n             (rst_n),
        .clr_i             (acc_clr),
        .en_i              (acc_en),
        .mismatch_i        (mismatch),
        .vec_i             (vec_q),
        .err_count_o       (err_count),
        .first_err_vec_o   (first_err_vec),
        .first_err_valid_o (first_err_valid)
    );

    assign {dut_a, dut_b, dut_c, dut_d} = vec_q;
    assign busy = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done = (state_q == DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_hwt_sweep_checker.sv
// Directed bench for hwt_sweep_checker: five instances with different
// settle/pass/width parameters, each fed by a behavioural cone model.
module tb_hwt_sweep_checker;

    localparam int unsigned N = 5;
    localparam int unsigned S_TAB  [N] = '{1, 1, 1, 0, 15};
    localparam int unsigned P_TAB  [N] = '{1, 3, 1, 1, 1};
    localparam int unsigned CW_TAB [N] = '{8, 8, 3, 8, 8};

    localparam int M_CLEAN  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_TROJAN = 2;
    localparam int M_INVERT = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] start_v;
    int           mode_v [N];

    wire [N-1:0]  busy_v, done_v, pass_v, fvalid_v, y_v;
    wire [3:0]    pins_v [N];
    wire [3:0]    fvec_v [N];
    wire [7:0]    err_v  [N];

    int checks;
    int errors;

    // Pin sequence monitor for instance 0.
    logic [3:0] last_pins;
    int         seq_changes;
    int         seq_err;

    function automatic logic model_y(input int mode, input logic [3:0] v);
        logic g;
        g = v[0] & ((v[3] & v[2]) | v[1]);
        case (mode)
            M_CLEAN:  return g;
            M_STUCK0: return 1'b0;
            M_TROJAN: return (v == 4'hF) ? ~g : g;
            default:  return ~g;
        endcase
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int unsigned CW = CW_TAB[gi];
        logic          a, b, c, d;
        logic [CW-1:0] err_w;

        hwt_sweep_checker #(
            .SETTLE_CYCLES (S_TAB[gi]),
            .PASSES        (P_TAB[gi]),
            .CNT_W         (CW)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start_v[gi]),
            .dut_a           (a),
            .dut_b           (b),
            .dut_c           (c),
            .dut_d           (d),
            .dut_y           (y_v[gi]),
            .busy            (busy_v[gi]),
            .done            (done_v[gi]),
            .pass            (pass_v[gi]),
            .err_count       (err_w),
            .first_err_vec   (fvec_v[gi]),
            .first_err_valid (fvalid_v[gi])
        );

        assign pins_v[gi] = {a, b, c, d};
        assign err_v[gi]  = 8'(err_w);
        assign y_v[gi]    = model_y(mode_v[gi], {a, b, c, d});
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy_v[0] && pins_v[0] != last_pins) begin
            if (pins_v[0] != last_pins + 4'd1) seq_err++;
            seq_changes++;
            last_pins = pins_v[0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start so the DUT sees it on edge 0; returns just after edge 0.
    task automatic start_run(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    // Counts edges after the start edge until done rises; optionally pokes start while busy.
    task automatic wait_done(input int idx, input int budget, input bit poke, output int edges);
        edges = 0;
        while (edges < budget) begin
            @(posedge clk);
            edges++;
            #1;
            if (done_v[idx]) break;
            if (poke) start_v[idx] = (edges % 7 == 0);
        end
        start_v[idx] = 1'b0;
        check($sformatf("done_reached[%0d]", idx), 32'(done_v[idx]), 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},   32'(busy_v[0]),   32'd0);
        check({tag, "_done"},   32'(done_v[0]),   32'd0);
        check({tag, "_pass"},   32'(pass_v[0]),   32'd0);
        check({tag, "_err"},    32'(err_v[0]),    32'd0);
        check({tag, "_fvec"},   32'(fvec_v[0]),   32'd0);
        check({tag, "_fvalid"}, 32'(fvalid_v[0]), 32'd0);
        check({tag, "_pins"},   32'(pins_v[0]),   32'd0);
    endtask

    initial begin
        int edges;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start_v = '0;
        mode_v  = '{M_CLEAN, M_TROJAN, M_INVERT, M_CLEAN, M_CLEAN};
        last_pins   = 4'd0;
        seq_changes = 0;
        seq_err     = 0;

        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        check("reset_busy_all", 32'(busy_v), 32'd0);
        check("reset_done_all", 32'(done_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean cone, S=1, P=1: done at edge 33.
        start_run(0);
        check("clean_busy_after_start", 32'(busy_v[0]), 32'd1);
        wait_done(0, 400, 1'b0, edges);
        check("clean_done_edge", 32'(edges), 32'd33);
        check("clean_pass", 32'(pass_v[0]), 32'd1);
        check("clean_err", 32'(err_v[0]), 32'd0);
        check("clean_fvalid", 32'(fvalid_v[0]), 32'd0);
        check("clean_busy_end", 32'(busy_v[0]), 32'd0);
        check("clean_pins_hold", 32'(pins_v[0]), 32'hF);
        check("clean_seq_steps", 32'(seq_changes), 32'd15);
        check("clean_seq_order", 32'(seq_err), 32'd0);

        // Stuck-at-0, restarted straight from DONE.
        mode_v[0] = M_STUCK0;
        start_run(0);
        check("restart_done_cleared", 32'(done_v[0]), 32'd0);
        check("restart_pass_cleared", 32'(pass_v[0]), 32'd0);
        wait_done(0, 400, 1'b0, edges);
        check("stuck0_done_edge", 32'(edges), 32'd33);
        check("stuck0_err", 32'(err_v[0]), 32'd5);
        check("stuck0_fvec", 32'(fvec_v[0]), 32'h3);
        check("stuck0_fvalid", 32'(fvalid_v[0]), 32'd1);
        check("stuck0_pass", 32'(pass_v[0]), 32'd0);

        // Trojan flipping only vector F.
        mode_v[0] = M_TROJAN;
        start_run(0);
        wait_done(0, 400, 1'b0, edges);
        check("trojan_err", 32'(err_v[0]), 32'd1);
        check("trojan_fvec", 32'(fvec_v[0]), 32'hF);
        check("trojan_pass", 32'(pass_v[0]), 32'd0);

        // Trojan over three passes: done at 16*2*3+1.
        start_run(1);
        wait_done(1, 400, 1'b0, edges);
        check("trojan3_done_edge", 32'(edges), 32'd97);
        check("trojan3_err", 32'(err_v[1]), 32'd3);
        check("trojan3_fvec", 32'(fvec_v[1]), 32'hF);

        // Inverted cone, 3-bit counter saturates at 7.
        start_run(2);
        wait_done(2, 400, 1'b0, edges);
        check("invert_done_edge", 32'(edges), 32'd33);
        check("invert_err_sat", 32'(err_v[2]), 32'd7);
        check("invert_fvec", 32'(fvec_v[2]), 32'h0);
        check("invert_fvalid", 32'(fvalid_v[2]), 32'd1);
        check("invert_pass", 32'(pass_v[2]), 32'd0);

        // Settle extremes.
        start_run(3);
        wait_done(3, 400, 1'b0, edges);
        check("settle0_done_edge", 32'(edges), 32'd17);
        check("settle0_pass", 32'(pass_v[3]), 32'd1);
        start_run(4);
        wait_done(4, 400, 1'b0, edges);
        check("settle15_done_edge", 32'(edges), 32'd257);
        check("settle15_pass", 32'(pass_v[4]), 32'd1);

        // Reset during vector 6 in DRIVE (entered at edge 13).
        mode_v[0] = M_STUCK0;
        start_run(0);
        repeat (13) @(posedge clk);
        #1;
        check("midrun_pins", 32'(pins_v[0]), 32'd6);
        check("midrun_busy", 32'(busy_v[0]), 32'd1);
        check("midrun_err", 32'(err_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh run with start pokes while busy; they must not restart it.
        start_run(0);
        wait_done(0, 400, 1'b1, edges);
        check("fresh_done_edge", 32'(edges), 32'd33);
        check("fresh_err", 32'(err_v[0]), 32'd5);
        check("fresh_fvec", 32'(fvec_v[0]), 32'h3);
        check("fresh_pass", 32'(pass_v[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
